// File: rtl/wb_pkg.sv
// Shared widths and the buffered write entry for the writeback unit.
package wb_pkg;
   localparam int WB_DATA_W = 16;
   localparam int WB_ADDR_W = 3;
   localparam int NREG      = 2**WB_ADDR_W;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_if.sv
// Source handshakes, register-file write port and status for the writeback unit.
interface wb_if import wb_pkg::*; #(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  alu_valid;
   logic [ADDR_W-1:0]     alu_addr;
   logic [DATA_W-1:0]     alu_data;
   logic                  alu_ready;
   logic                  mem_valid;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_data;
   logic                  mem_ready;
   logic                  hold;
   logic [ADDR_W-1:0]     c_addr;
   logic [DATA_W-1:0]     ref_c;
   logic                  rwe;
   logic [2**ADDR_W-1:0]  pending;
   logic [CNT_W-1:0]      count;

   modport master (
      output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, hold,
      input  alu_ready, mem_ready, c_addr, ref_c, rwe, pending, count
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, hold,
      output alu_ready, mem_ready, c_addr, ref_c, rwe, pending, count
   );
endinterface

// File: rtl/wb_fifo.sv
// Power-of-two FIFO exposing every slot and its occupancy for address tracking.
module wb_fifo #(
   parameter  int WIDTH = 19,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic [WIDTH-1:0]            push_data,
   input  logic                        pop,
   output logic [WIDTH-1:0]            head,
   output logic                        full,
   output logic                        empty,
   output logic [CNT_W-1:0]            count,
   output logic [DEPTH-1:0][WIDTH-1:0] entries,
   output logic [DEPTH-1:0]            entry_valid
);
   logic [DEPTH-1:0][WIDTH-1:0] store;
   logic [PTR_W-1:0]            wr_ptr;
   logic [PTR_W-1:0]            rd_ptr;
   logic                        wr_en;
   logic                        rd_en;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

   // Payload needs no reset: every consumer qualifies it with occupancy.
   always_ff @(posedge clk) begin
      if (wr_en) store[wr_ptr] <= push_data;
   end

   assign head    = store[rd_ptr];
   assign entries = store;

   for (genvar i = 0; i < DEPTH; i++) begin : g_vld
      logic [PTR_W-1:0] off;
      assign off            = PTR_W'(i) - rd_ptr;
      assign entry_valid[i] = ({1'b0, off} < count);
   end
endmodule

// File: rtl/writeback_unit.sv
// Arbitrates ALU and load results into an ordered buffer that drains to the register file.
module writeback_unit import wb_pkg::*; #(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DEPTH  = 4
) (
   input logic clk,
   input logic rst_n,
   wb_if.slave bus
);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int W      = ADDR_W + DATA_W;
   localparam int NREG_L = 2**ADDR_W;

   logic                    last_mem;
   logic                    mem_win;
   logic                    alu_win;
   logic                    push;
   logic                    pop;
   logic [W-1:0]            push_data;
   logic [W-1:0]            head;
   logic                    full;
   logic                    empty;
   logic [CNT_W-1:0]        count_q;
   logic [DEPTH-1:0][W-1:0] entries;
   logic [DEPTH-1:0]        entry_valid;
   logic [NREG_L-1:0]       pend;

   // Contested cycles go to whichever source did not win the previous grant.
   assign mem_win       = bus.mem_valid && (!bus.alu_valid || !last_mem);
   assign alu_win       = bus.alu_valid && !mem_win;
   assign bus.mem_ready = rst_n && !full && mem_win;
   assign bus.alu_ready = rst_n && !full && alu_win;

   assign push      = bus.mem_ready || bus.alu_ready;
   assign push_data = bus.mem_ready ? {bus.mem_addr, bus.mem_data}
                                    : {bus.alu_addr, bus.alu_data};

   always_ff @(posedge clk) begin
      if (!rst_n) last_mem <= 1'b0;
      else if (push) last_mem <= bus.mem_ready;
   end

   wb_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .push_data   (push_data),
      .pop         (pop),
      .head        (head),
      .full        (full),
      .empty       (empty),
      .count       (count_q),
      .entries     (entries),
      .entry_valid (entry_valid)
   );

   assign pop        = rst_n && !empty && !bus.hold;
   assign bus.rwe    = pop;
   assign bus.c_addr = empty ? '0 : head[W-1:DATA_W];
   assign bus.ref_c  = empty ? '0 : head[DATA_W-1:0];
   assign bus.count  = count_q;

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i]) pend[entries[i][W-1:DATA_W]] = 1'b1;
      end
   end

   assign bus.pending = pend;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed checks of arbitration, ordering, hold/full, reset and pointer wrap.
module tb_writeback_unit;
   import wb_pkg::*;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   wb_entry_t sb[$];
   wb_entry_t ent;

   always #5 clk = ~clk;

   wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

   writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.alu_valid = 1'b1; bus.alu_addr = '0; bus.alu_data = '0;
      bus.mem_valid = 1'b1; bus.mem_addr = '0; bus.mem_data = '0;
      bus.hold = 1'b0;

      // reset state
      step(); step();
      chk("rst_alu_ready", 32'(bus.alu_ready), 0);
      chk("rst_mem_ready", 32'(bus.mem_ready), 0);
      chk("rst_rwe", 32'(bus.rwe), 0);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_pending", 32'(bus.pending), 0);
      chk("rst_c_addr", 32'(bus.c_addr), 0);
      chk("rst_ref_c", 32'(bus.ref_c), 0);
      bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; rst_n = 1'b1;
      step();

      // single write
      bus.alu_valid = 1'b1; bus.alu_addr = 3'd3; bus.alu_data = 16'h1234;
      #1;
      chk("single_alu_ready", 32'(bus.alu_ready), 1);
      chk("single_mem_ready", 32'(bus.mem_ready), 0);
      step();
      bus.alu_valid = 1'b0;
      #1;
      chk("single_rwe", 32'(bus.rwe), 1);
      chk("single_c_addr", 32'(bus.c_addr), 3);
      chk("single_ref_c", 32'(bus.ref_c), 32'h1234);
      chk("single_pending", 32'(bus.pending), 32'h08);
      chk("single_count", 32'(bus.count), 1);
      step();
      chk("single_rwe_after", 32'(bus.rwe), 0);
      chk("single_pending_after", 32'(bus.pending), 0);

      // contention: mem, alu, mem, alu
      for (int k = 0; k < 4; k++) begin
         bus.mem_valid = 1'b1; bus.mem_addr = 3'd1; bus.mem_data = 16'hB000 + 16'(k);
         bus.alu_valid = 1'b1; bus.alu_addr = 3'd2; bus.alu_data = 16'hC000 + 16'(k);
         #1;
         chk($sformatf("cont_mem_ready_%0d", k), 32'(bus.mem_ready), (k % 2 == 0) ? 1 : 0);
         chk($sformatf("cont_alu_ready_%0d", k), 32'(bus.alu_ready), (k % 2 == 0) ? 0 : 1);
         if (k > 0) begin
            chk($sformatf("cont_rwe_%0d", k), 32'(bus.rwe), 1);
            chk($sformatf("cont_c_addr_%0d", k), 32'(bus.c_addr), ((k - 1) % 2 == 0) ? 1 : 2);
            chk($sformatf("cont_ref_c_%0d", k), 32'(bus.ref_c),
                ((k - 1) % 2 == 0) ? 32'hB000 + 32'(k - 1) : 32'hC000 + 32'(k - 1));
         end
         step();
      end
      bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
      #1;
      chk("cont_last_rwe", 32'(bus.rwe), 1);
      chk("cont_last_c_addr", 32'(bus.c_addr), 2);
      chk("cont_last_ref_c", 32'(bus.ref_c), 32'hC003);
      step();
      chk("cont_drained", 32'(bus.count), 0);

      // hold until full
      bus.hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.alu_valid = 1'b1; bus.alu_addr = 3'(i); bus.alu_data = 16'h00A0 + 16'(i);
         #1;
         chk($sformatf("hold_ready_%0d", i), 32'(bus.alu_ready), 1);
         chk($sformatf("hold_rwe_%0d", i), 32'(bus.rwe), 0);
         step();
      end
      bus.alu_addr = 3'd4; bus.alu_data = 16'h00A4;
      #1;
      chk("full_count", 32'(bus.count), 4);
      chk("full_alu_ready", 32'(bus.alu_ready), 0);
      chk("full_pending", 32'(bus.pending), 32'h0F);
      step();
      bus.hold = 1'b0;
      #1;
      chk("full_no_pop_credit", 32'(bus.alu_ready), 0);
      chk("release_rwe_0", 32'(bus.rwe), 1);
      chk("release_c_addr_0", 32'(bus.c_addr), 0);
      chk("release_ref_c_0", 32'(bus.ref_c), 32'hA0);
      step();
      bus.alu_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         #1;
         chk($sformatf("release_rwe_%0d", i), 32'(bus.rwe), 1);
         chk($sformatf("release_c_addr_%0d", i), 32'(bus.c_addr), 32'(i));
         chk($sformatf("release_ref_c_%0d", i), 32'(bus.ref_c), 32'hA0 + 32'(i));
         step();
      end
      chk("release_count", 32'(bus.count), 0);
      chk("release_rwe_idle", 32'(bus.rwe), 0);

      // same address twice
      bus.alu_valid = 1'b1; bus.alu_addr = 3'd5; bus.alu_data = 16'h1111;
      #1;
      chk("same_alu_ready", 32'(bus.alu_ready), 1);
      step();
      bus.alu_valid = 1'b0;
      bus.mem_valid = 1'b1; bus.mem_addr = 3'd5; bus.mem_data = 16'h2222;
      #1;
      chk("same_mem_ready", 32'(bus.mem_ready), 1);
      chk("same_rwe_1", 32'(bus.rwe), 1);
      chk("same_ref_c_1", 32'(bus.ref_c), 32'h1111);
      chk("same_pending_1", 32'(bus.pending), 32'h20);
      step();
      bus.mem_valid = 1'b0;
      #1;
      chk("same_c_addr_2", 32'(bus.c_addr), 5);
      chk("same_ref_c_2", 32'(bus.ref_c), 32'h2222);
      chk("same_pending_2", 32'(bus.pending), 32'h20);
      step();
      chk("same_pending_clear", 32'(bus.pending), 0);
      chk("same_rwe_idle", 32'(bus.rwe), 0);

      // reset mid-run with entries buffered; last grant before reset is mem
      bus.hold = 1'b1;
      bus.alu_valid = 1'b1; bus.alu_addr = 3'd6; bus.alu_data = 16'h00D0;
      #1; chk("mid_ready_0", 32'(bus.alu_ready), 1); step();
      bus.alu_addr = 3'd7; bus.alu_data = 16'h00D1;
      #1; chk("mid_ready_1", 32'(bus.alu_ready), 1); step();
      bus.alu_valid = 1'b0;
      bus.mem_valid = 1'b1; bus.mem_addr = 3'd0; bus.mem_data = 16'h00D2;
      #1; chk("mid_ready_2", 32'(bus.mem_ready), 1); step();
      bus.mem_valid = 1'b0;
      #1;
      chk("mid_count", 32'(bus.count), 3);
      chk("mid_pending", 32'(bus.pending), 32'hC1);
      rst_n = 1'b0; bus.hold = 1'b0;
      #1;
      chk("mid_rwe_in_reset", 32'(bus.rwe), 0);
      step();
      rst_n = 1'b1;
      #1;
      chk("mid_count_after", 32'(bus.count), 0);
      chk("mid_rwe_after", 32'(bus.rwe), 0);
      chk("mid_pending_after", 32'(bus.pending), 0);
      chk("mid_ref_c_after", 32'(bus.ref_c), 0);
      bus.mem_valid = 1'b1; bus.mem_addr = 3'd4; bus.mem_data = 16'hF0F0;
      bus.alu_valid = 1'b1; bus.alu_addr = 3'd3; bus.alu_data = 16'h0E0E;
      #1;
      chk("mid_rr_mem_first", 32'(bus.mem_ready), 1);
      chk("mid_rr_alu_wait", 32'(bus.alu_ready), 0);
      step();
      bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
      #1;
      chk("mid_new_c_addr", 32'(bus.c_addr), 4);
      chk("mid_new_ref_c", 32'(bus.ref_c), 32'hF0F0);
      step();
      chk("mid_new_drained", 32'(bus.count), 0);

      // ten back-to-back accepts across pointer wrap
      for (int k = 0; k <= 10; k++) begin
         if (k < 10) begin
            bus.alu_valid = 1'b1; bus.alu_addr = 3'(k % 8); bus.alu_data = 16'hE000 + 16'(k);
         end else begin
            bus.alu_valid = 1'b0;
         end
         #1;
         if (k > 0) begin
            ent = sb.pop_front();
            chk($sformatf("wrap_rwe_%0d", k), 32'(bus.rwe), 1);
            chk($sformatf("wrap_c_addr_%0d", k), 32'(bus.c_addr), 32'(ent.addr));
            chk($sformatf("wrap_ref_c_%0d", k), 32'(bus.ref_c), 32'(ent.data));
         end
         if (k < 10) begin
            chk($sformatf("wrap_ready_%0d", k), 32'(bus.alu_ready), 1);
            ent.addr = 3'(k % 8);
            ent.data = 16'hE000 + 16'(k);
            sb.push_back(ent);
         end
         step();
      end
      chk("wrap_count", 32'(bus.count), 0);
      chk("wrap_rwe_idle", 32'(bus.rwe), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
